// File: rtl/if_fetch_if.sv
// Fetch-stage signal bundle: PC register, instruction memory and IF/ID register.
interface if_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc;
  logic                  taken;
  logic                  pc_en;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  id_stall;
  logic                  id_valid;
  logic [DATA_WIDTH-1:0] id_inst;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [ADDR_WIDTH-1:0] id_pcn;

  // Fetch controller side
  modport master (
    input  pc, taken, imem_gnt, imem_rvalid, imem_rdata, id_stall,
    output pc_en, imem_req, imem_addr, id_valid, id_inst, id_pc, id_pcn
  );

  // Environment side (PC register, memory, ID stage)
  modport slave (
    output pc, taken, imem_gnt, imem_rvalid, imem_rdata, id_stall,
    input  pc_en, imem_req, imem_addr, id_valid, id_inst, id_pc, id_pcn
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: one outstanding imem request, IF/ID register,
// one-entry skid buffer for ID back-pressure, wrong-path kill on redirect.
module if_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {ISSUE, REQ, WAIT, HOLD} state_t;

  state_t                state_q, state_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [ADDR_WIDTH-1:0] skid_pcn_q, skid_pcn_d;
  logic                  id_valid_q, id_valid_d;
  logic [DATA_WIDTH-1:0] id_inst_q, id_inst_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [ADDR_WIDTH-1:0] id_pcn_q, id_pcn_d;
  logic                  accept_c;
  logic                  out_busy_c;

  // Next-state, request tracking, skid capture and IF/ID register update
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    req_addr_d  = req_addr_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_pcn_d  = skid_pcn_q;
    id_valid_d  = id_valid_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_pcn_d    = id_pcn_q;
    accept_c    = 1'b0;
    out_busy_c  = id_valid_q & bus.id_stall;

    unique case (state_q)
      ISSUE: begin
        // A redirecting PC is not latched; wait for the target to land.
        if (!bus.taken) begin
          req_addr_d = bus.pc;
          state_d    = REQ;
        end
      end
      REQ: begin
        // The request stays up until granted; a redirect only marks it stale.
        if (bus.taken)    drop_d  = 1'b1;
        if (bus.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (drop_q || bus.taken) begin
            drop_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            accept_c = 1'b1;
            if (out_busy_c) begin
              skid_inst_d = bus.imem_rdata;
              skid_pc_d   = req_addr_q;
              skid_pcn_d  = req_addr_q + PC_STEP;
              state_d     = HOLD;
            end else begin
              state_d = ISSUE;
            end
          end
        end else if (bus.taken) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        // Leaving HOLD either drains the skid into IF/ID or discards it.
        if (bus.taken || !out_busy_c) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase

    if (bus.taken) begin
      id_valid_d = 1'b0;
    end else if (!out_busy_c) begin
      if (state_q == HOLD) begin
        id_valid_d = 1'b1;
        id_inst_d  = skid_inst_q;
        id_pc_d    = skid_pc_q;
        id_pcn_d   = skid_pcn_q;
      end else if (accept_c) begin
        id_valid_d = 1'b1;
        id_inst_d  = bus.imem_rdata;
        id_pc_d    = req_addr_q;
        id_pcn_d   = req_addr_q + PC_STEP;
      end else begin
        id_valid_d = 1'b0;
      end
    end
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ISSUE;
      drop_q      <= 1'b0;
      req_addr_q  <= '0;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_pcn_q  <= '0;
      id_valid_q  <= 1'b0;
      id_inst_q   <= NOP_INST;
      id_pc_q     <= '0;
      id_pcn_q    <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_addr_q  <= req_addr_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_pcn_q  <= skid_pcn_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_pcn_q    <= id_pcn_d;
    end
  end

  assign bus.imem_req  = (state_q == REQ) & ~rst;
  assign bus.imem_addr = req_addr_q;
  assign bus.pc_en     = (bus.taken | accept_c) & ~rst;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pcn    = id_pcn_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: PC register model, hand-driven imem
// handshake, and a scoreboard of instructions expected to reach ID.
module tb_if_fetch_ctrl;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pcn;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc_q;
  logic [31:0] target;
  exp_t        sb[$];
  int          checks;
  int          errors;
  int          cyc;
  int          a1, a2, a3, a_tmp;

  if_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  if_fetch_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: +4 per enable, branch target on redirect
  always @(posedge clk) begin
    if (rst)             pc_q <= 32'd0;
    else if (bus.pc_en)  pc_q <= bus.taken ? target : pc_q + 32'd4;
  end
  assign bus.pc = pc_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // An instruction is consumed by ID in any cycle it is valid and not stalled
  task automatic sb_monitor();
    exp_t e;
    if (bus.id_valid === 1'b1 && bus.id_stall === 1'b0) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(bus.id_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_inst", bus.id_inst, e.inst);
        check("sb_pc",   bus.id_pc,   e.pc);
        check("sb_pcn",  bus.id_pcn,  e.pcn);
      end
    end
  endtask

  task automatic tick();
    sb_monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    settle();
    while (bus.imem_req !== 1'b1 && n < 10) begin
      tick();
      settle();
      n++;
    end
    check("req_timeout", 32'(bus.imem_req), 32'd1);
  endtask

  // Normal fetch: gnt on first REQ cycle, rvalid one cycle later, accepted
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, output int acc_cyc);
    wait_req();
    check("imem_addr", bus.imem_addr, addr);
    bus.imem_gnt = 1'b1;
    settle();
    check("pc_en_gnt", 32'(bus.pc_en), 32'd0);
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    sb.push_back({data, addr, addr + 32'd4});
    settle();
    check("pc_en_accept", 32'(bus.pc_en), 32'd1);
    acc_cyc = cyc;
    tick();
    bus.imem_rvalid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    target = 32'd0;
    bus.taken       = 1'b1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.id_stall    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    settle();
    check("rst_req",   32'(bus.imem_req), 32'd0);
    check("rst_pc_en", 32'(bus.pc_en),    32'd0);
    check("rst_valid", 32'(bus.id_valid), 32'd0);
    check("rst_inst",  bus.id_inst, 32'h0000_0013);
    check("rst_pc",    bus.id_pc,   32'd0);
    check("rst_pcn",   bus.id_pcn,  32'd0);
    bus.taken = 1'b0;
    rst = 1'b0;
    settle();
    check("issue_no_req", 32'(bus.imem_req), 32'd0);
    tick();

    // Single fetch at PC 0
    fetch(32'h0, 32'h0050_0093, a1);
    settle();
    check("t1_valid", 32'(bus.id_valid), 32'd1);
    check("t1_inst",  bus.id_inst, 32'h0050_0093);
    check("t1_pc_en_idle", 32'(bus.pc_en), 32'd0);

    // Back-to-back: one instruction every 3 cycles
    fetch(32'h4, 32'h0010_0113, a2);
    fetch(32'h8, 32'h0020_0193, a3);
    check("t2_rate_a", 32'(a2 - a1), 32'd3);
    check("t2_rate_b", 32'(a3 - a2), 32'd3);

    // ID stall with a second response arriving: goes to skid
    fetch(32'hC, 32'h0030_0213, a_tmp);
    bus.id_stall = 1'b1;
    fetch(32'h10, 32'h00A0_0113, a_tmp);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("hold_no_req", 32'(bus.imem_req), 32'd0);
      check("hold_inst",   bus.id_inst, 32'h0030_0213);
      tick();
    end
    bus.id_stall = 1'b0;
    tick();
    settle();
    check("skid_inst",  bus.id_inst, 32'h00A0_0113);
    check("skid_pc",    bus.id_pc,   32'h10);
    check("skid_valid", 32'(bus.id_valid), 32'd1);
    tick();

    // Redirect while in WAIT; response arrives later and is dropped
    wait_req();
    check("after_skid_addr", bus.imem_addr, 32'h14);
    bus.imem_gnt = 1'b1;
    settle();
    tick();
    bus.imem_gnt = 1'b0;
    bus.taken = 1'b1;
    target    = 32'h100;
    settle();
    check("wait_taken_pc_en", 32'(bus.pc_en), 32'd1);
    tick();
    bus.taken = 1'b0;
    settle();
    check("wait_drop_pc_en", 32'(bus.pc_en), 32'd0);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    settle();
    check("drop_rvalid_pc_en", 32'(bus.pc_en), 32'd0);
    tick();
    bus.imem_rvalid = 1'b0;
    settle();
    check("drop_valid", 32'(bus.id_valid), 32'd0);
    fetch(32'h100, 32'h0040_0293, a_tmp);

    // Redirect in REQ with gnt held low: request stays stable, data dropped
    wait_req();
    bus.taken = 1'b1;
    target    = 32'h200;
    settle();
    check("req_taken_pc_en", 32'(bus.pc_en), 32'd1);
    tick();
    bus.taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("req_stable", 32'(bus.imem_req), 32'd1);
      check("req_addr_stable", bus.imem_addr, 32'h104);
      tick();
    end
    bus.imem_gnt = 1'b1;
    settle();
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0BAD;
    settle();
    check("req_drop_pc_en", 32'(bus.pc_en), 32'd0);
    tick();
    bus.imem_rvalid = 1'b0;

    // Redirect in ISSUE to the top of the address space
    bus.taken = 1'b1;
    target    = 32'hFFFF_FFFC;
    settle();
    check("issue_taken_pc_en", 32'(bus.pc_en), 32'd1);
    check("req_drop_valid",    32'(bus.id_valid), 32'd0);
    tick();
    bus.taken = 1'b0;
    settle();
    check("issue_stay", 32'(bus.imem_req), 32'd0);
    fetch(32'hFFFF_FFFC, 32'h0050_0313, a_tmp);
    settle();
    check("wrap_pcn", bus.id_pcn, 32'h0);

    // Reset mid-WAIT; late rvalid must be ignored
    wait_req();
    check("wrap_next_addr", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1'b1;
    settle();
    tick();
    bus.imem_gnt = 1'b0;
    rst = 1'b1;
    settle();
    check("rst_mid_req", 32'(bus.imem_req), 32'd0);
    tick();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1234_5678;
    settle();
    check("late_rvalid_pc_en", 32'(bus.pc_en), 32'd0);
    check("late_valid",        32'(bus.id_valid), 32'd0);
    check("late_inst",         bus.id_inst, 32'h0000_0013);
    tick();
    bus.imem_rvalid = 1'b0;
    fetch(32'h0, 32'h0060_0393, a_tmp);
    tick();
    tick();
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
